// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared IO header for the interrupt controller.
//   - Register addresses of the memory-mapped interface.
//   - Bit locations inside the CTRL and VECTOR registers.
//   - Bus encodings for active-low enables and the rw direction.
// No ports; imported by irq_ctrl and irq_prio_enc.
package irq_ctrl_pkg;

  // Bus encodings shared with the other IO slaves (timer, UART, GPIO).
  localparam logic ENABLE_  = 1'b0;  // active-low strobe asserted
  localparam logic DISABLE_ = 1'b1;  // active-low strobe deasserted
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  // Register map.
  localparam int IRQC_ADDR_STATUS = 0;
  localparam int IRQC_ADDR_MASK   = 1;
  localparam int IRQC_ADDR_VECTOR = 2;
  localparam int IRQC_ADDR_CTRL   = 3;

  // Field locations.
  localparam int IRQC_CTRL_GEN_LOC  = 0;
  localparam int IRQC_VEC_VALID_LOC = 31;
  localparam int IRQC_VEC_IDX_W     = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational priority encoder, lowest index wins.
// Parameters:
//   N      number of request bits (1..16)
// Ports:
//   req    in  N  request vector
//   valid  out 1  at least one request bit set
//   idx    out 4  index of the lowest set bit, 0 when valid=0
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]                req,
  output logic                        valid,
  output logic [IRQC_VEC_IDX_W-1:0]   idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IRQC_VEC_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller.
// Latches rising edges of peripheral irq levels into pending bits, applies a
// per-source mask and a global enable, and drives a registered CPU request
// plus a priority-encoded vector (lowest index wins).
//
// Build option: define IRQ_CTRL_SYNC_EN to pass irq_in through a 2-flop
// synchroniser before edge detection (adds 2 cycles of latency).
//
// Registers: 0 STATUS (read pending, write-1-to-clear), 1 MASK (r/w),
//            2 VECTOR (read-only {valid@31, idx@3:0}), 3 CTRL (bit0 = gen).
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   cs_, as_        chip select / address strobe, active-low
//   rw              1 = read, 0 = write
//   addr, wr_data   register select and write data
//   rd_data         registered read data, 0 outside the read response cycle
//   rdy_            active-low ready, one cycle after each access
//   irq_in          level requests, bit 0 is the timer
//   cpu_irq         registered request to the CPU
//   vec_valid       a pending, unmasked source exists
//   vec_idx         highest-priority pending, unmasked source
//
// Handshake: an access is any cycle sampled with cs_=0 and as_=0. The slave
// answers every access with rdy_=0 in the following cycle, with read data on
// rd_data in that same cycle; no wait states, back-to-back accesses each get
// their own rdy_ pulse.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int IRQ_NUM = 8,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cs_,
  input  logic                      as_,
  input  logic                      rw,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rdy_,
  input  logic [IRQ_NUM-1:0]        irq_in,
  output logic                      cpu_irq,
  output logic                      vec_valid,
  output logic [IRQC_VEC_IDX_W-1:0] vec_idx
);

  logic [IRQ_NUM-1:0]        src;
  logic [IRQ_NUM-1:0]        irq_d;
  logic [IRQ_NUM-1:0]        edge_bits;
  logic [IRQ_NUM-1:0]        pending;
  logic [IRQ_NUM-1:0]        mask;
  logic [IRQ_NUM-1:0]        w1c;
  logic                      gen;
  logic                      access;
  logic                      wr_status;
  logic                      wr_mask;
  logic                      wr_ctrl;
  logic [DATA_W-1:0]         rd_mux;
  logic                      enc_valid;
  logic [IRQC_VEC_IDX_W-1:0] enc_idx;
  logic                      unused_wr_data;

  // Only the low IRQ_NUM bits of write data carry register state.
  assign unused_wr_data = ^wr_data[DATA_W-1:IRQ_NUM];

`ifdef IRQ_CTRL_SYNC_EN
  logic [IRQ_NUM-1:0] sync_1;
  logic [IRQ_NUM-1:0] sync_2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= irq_in;
      sync_2 <= sync_1;
    end
  end

  assign src = sync_2;
`else
  assign src = irq_in;
`endif

  // irq_d resets to 0, so a source still high after reset is a fresh edge.
  assign edge_bits = src & ~irq_d;

  assign access    = (cs_ == ENABLE_) && (as_ == ENABLE_);
  assign wr_status = access && (rw == WRITE) && (addr == ADDR_W'(IRQC_ADDR_STATUS));
  assign wr_mask   = access && (rw == WRITE) && (addr == ADDR_W'(IRQC_ADDR_MASK));
  assign wr_ctrl   = access && (rw == WRITE) && (addr == ADDR_W'(IRQC_ADDR_CTRL));
  assign w1c       = wr_status ? wr_data[IRQ_NUM-1:0] : '0;

  // Read mux; unused high bits and unmapped addresses read as 0.
  always_comb begin
    rd_mux = '0;
    if (addr == ADDR_W'(IRQC_ADDR_STATUS)) begin
      rd_mux[IRQ_NUM-1:0] = pending;
    end else if (addr == ADDR_W'(IRQC_ADDR_MASK)) begin
      rd_mux[IRQ_NUM-1:0] = mask;
    end else if (addr == ADDR_W'(IRQC_ADDR_VECTOR)) begin
      rd_mux[IRQC_VEC_VALID_LOC]    = vec_valid;
      rd_mux[IRQC_VEC_IDX_W-1:0]    = vec_idx;
    end else if (addr == ADDR_W'(IRQC_ADDR_CTRL)) begin
      rd_mux[IRQC_CTRL_GEN_LOC]     = gen;
    end
  end

  irq_prio_enc #(
    .N     (IRQ_NUM)
  ) u_prio_enc (
    .req   (pending & mask),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data   <= '0;
      rdy_      <= DISABLE_;
      irq_d     <= '0;
      pending   <= '0;
      mask      <= '0;
      gen       <= 1'b0;
      cpu_irq   <= 1'b0;
      vec_valid <= 1'b0;
      vec_idx   <= '0;
    end else begin
      rdy_    <= access ? ENABLE_ : DISABLE_;
      rd_data <= (access && (rw == READ)) ? rd_mux : '0;
      irq_d   <= src;
      // Clear first, then OR in new edges: a same-cycle set wins over W1C.
      pending <= (pending & ~w1c) | edge_bits;
      if (wr_mask) begin
        mask <= wr_data[IRQ_NUM-1:0];
      end
      if (wr_ctrl) begin
        gen <= wr_data[IRQC_CTRL_GEN_LOC];
      end
      // Built from registered pending/mask, so an edge latched at k shows
      // on cpu_irq after k+1.
      cpu_irq   <= gen & (|(pending & mask));
      vec_valid <= enc_valid;
      vec_idx   <= enc_idx;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed bench for irq_ctrl. Every bus access pushes its
// expected rd_data into exp_q; a monitor pops and compares on each rdy_
// pulse. Sideband outputs (cpu_irq, vec_*) are checked at fixed cycles.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int IRQ_NUM = 8;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 2;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic                clk;
  logic                reset;
  logic                cs_;
  logic                as_;
  logic                rw;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   rd_data;
  logic                rdy_;
  logic [IRQ_NUM-1:0]  irq_in;
  logic                cpu_irq;
  logic                vec_valid;
  logic [3:0]          vec_idx;

  logic [DATA_W-1:0]   exp_q[$];
  int                  errors;
  int                  checks;

  irq_ctrl #(
    .IRQ_NUM   (IRQ_NUM),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cs_       (cs_),
    .as_       (as_),
    .rw        (rw),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rdy_      (rdy_),
    .irq_in    (irq_in),
    .cpu_irq   (cpu_irq),
    .vec_valid (vec_valid),
    .vec_idx   (vec_idx)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: called at a negedge, drive one access, return at the next
  // negedge with the bus released (a following call makes it back-to-back).
  task automatic bus_wr(input int a, input logic [DATA_W-1:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = WRITE; addr = ADDR_W'(a); wr_data = d;
    exp_q.push_back('0);
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  task automatic bus_rd(input int a, input logic [DATA_W-1:0] exp);
    cs_ = 1'b0; as_ = 1'b0; rw = READ; addr = ADDR_W'(a); wr_data = '0;
    exp_q.push_back(exp);
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rdy_ === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_rdy: got rdy_=0 expected no response");
      end else begin
        chk("sb_rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = READ; addr = '0; wr_data = '0;
    irq_in = '0;

    // Reset
    tick(2);
    chk("rst_cpu_irq", 32'(cpu_irq), 0);
    chk("rst_vec_valid", 32'(vec_valid), 0);
    chk("rst_vec_idx", 32'(vec_idx), 0);
    chk("rst_rdy", 32'(rdy_), 1);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    bus_rd(IRQC_ADDR_MASK, 32'h0);

    // Basic path
    bus_wr(IRQC_ADDR_MASK, 32'h01);
    bus_wr(IRQC_ADDR_CTRL, 32'h1);
    irq_in = 8'h01;
    tick(1);
    irq_in = 8'h00;
    tick(SYNC_LAT);
    chk("basic_cpu_irq_k", 32'(cpu_irq), 0);
    tick(1);
    chk("basic_cpu_irq_k1", 32'(cpu_irq), 1);
    chk("basic_vec_valid", 32'(vec_valid), 1);
    chk("basic_vec_idx", 32'(vec_idx), 0);
    bus_rd(IRQC_ADDR_STATUS, 32'h01);
    bus_rd(IRQC_ADDR_VECTOR, 32'h8000_0000);
    bus_wr(IRQC_ADDR_VECTOR, 32'hFFFF_FFFF);
    bus_rd(IRQC_ADDR_VECTOR, 32'h8000_0000);
    bus_wr(IRQC_ADDR_STATUS, 32'h01);
    chk("basic_w1c_cpu_hold", 32'(cpu_irq), 1);
    tick(1);
    chk("basic_w1c_cpu_drop", 32'(cpu_irq), 0);
    chk("basic_w1c_vec_valid", 32'(vec_valid), 0);

    // Priority
    bus_wr(IRQC_ADDR_MASK, 32'hFF);
    irq_in = 8'h24;
    tick(1);
    irq_in = 8'h00;
    tick(SYNC_LAT + 1);
    chk("prio_cpu_irq", 32'(cpu_irq), 1);
    chk("prio_idx_2", 32'(vec_idx), 2);
    bus_wr(IRQC_ADDR_STATUS, 32'h04);
    tick(1);
    chk("prio_idx_5", 32'(vec_idx), 5);
    chk("prio_valid_5", 32'(vec_valid), 1);
    bus_wr(IRQC_ADDR_STATUS, 32'h20);
    tick(1);
    chk("prio_empty_valid", 32'(vec_valid), 0);
    chk("prio_empty_cpu", 32'(cpu_irq), 0);
    chk("prio_empty_idx", 32'(vec_idx), 0);

    // Collision: W1C and a fresh edge on bit 3 in the same cycle
    irq_in = 8'h08;
    tick(1);
    irq_in = 8'h00;
    tick(SYNC_LAT + 2);
    bus_rd(IRQC_ADDR_STATUS, 32'h08);
    irq_in = 8'h08;
    tick(SYNC_LAT);
    bus_wr(IRQC_ADDR_STATUS, 32'h08);
    bus_rd(IRQC_ADDR_STATUS, 32'h08);
    irq_in = 8'h00;
    tick(4);
    bus_wr(IRQC_ADDR_STATUS, 32'hFF);
    tick(2);
    chk("coll_cleared_cpu", 32'(cpu_irq), 0);

    // Mask and global enable
    bus_wr(IRQC_ADDR_MASK, 32'h00);
    irq_in = 8'h02;
    tick(1);
    irq_in = 8'h00;
    tick(SYNC_LAT + 2);
    chk("mask_off_cpu", 32'(cpu_irq), 0);
    chk("mask_off_valid", 32'(vec_valid), 0);
    bus_rd(IRQC_ADDR_STATUS, 32'h02);
    bus_wr(IRQC_ADDR_MASK, 32'h02);
    chk("unmask_cpu_k", 32'(cpu_irq), 0);
    tick(1);
    chk("unmask_cpu_k1", 32'(cpu_irq), 1);
    chk("unmask_idx", 32'(vec_idx), 1);
    bus_wr(IRQC_ADDR_CTRL, 32'h0);
    chk("gen_off_cpu_k", 32'(cpu_irq), 1);
    tick(1);
    chk("gen_off_cpu_k1", 32'(cpu_irq), 0);
    chk("gen_off_valid", 32'(vec_valid), 1);
    bus_rd(IRQC_ADDR_STATUS, 32'h02);
    bus_rd(IRQC_ADDR_CTRL, 32'h0);
    bus_rd(IRQC_ADDR_MASK, 32'h02);
    bus_wr(IRQC_ADDR_CTRL, 32'h1);
    bus_wr(IRQC_ADDR_STATUS, 32'h02);
    tick(2);

    // Held level, then reset mid-operation
    bus_wr(IRQC_ADDR_MASK, 32'h01);
    irq_in = 8'h01;
    tick(SYNC_LAT + 2);
    bus_rd(IRQC_ADDR_STATUS, 32'h01);
    chk("held_cpu_on", 32'(cpu_irq), 1);
    bus_wr(IRQC_ADDR_STATUS, 32'h01);
    tick(2);
    bus_rd(IRQC_ADDR_STATUS, 32'h00);
    chk("held_cpu_off", 32'(cpu_irq), 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_cpu", 32'(cpu_irq), 0);
    chk("mid_rst_rdy", 32'(rdy_), 1);
    chk("mid_rst_valid", 32'(vec_valid), 0);
    tick(SYNC_LAT);
    bus_rd(IRQC_ADDR_STATUS, 32'h00);
    bus_rd(IRQC_ADDR_STATUS, 32'h01);
    bus_rd(IRQC_ADDR_MASK, 32'h00);
    bus_rd(IRQC_ADDR_CTRL, 32'h0);
    chk("post_rst_cpu", 32'(cpu_irq), 0);
    irq_in = 8'h00;

    // Final report
    tick(3);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
